systolic_result_drain: RTL and testbench

- Read-out end of the 4x4 systolic PE array: snapshots every PE's accumulated 16-bit C value once a matrix product completes.
- Streams the 16 results out one word at a time over a valid/ready interface, then pulses an accumulator-clear toward the array.
- Sits between the PE grid's C outputs and the result sink (memory writer or host port).

---
 rtl/systolic_result_drain_if.sv | 25 ++
 rtl/systolic_result_drain.sv | 182 ++++++++++++++++++
 tb/tb_systolic_result_drain.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// Result stream from the systolic drain to its sink (memory writer or host port).
//   master: drives out_valid/out_data/out_row/out_col/out_last, samples out_ready
//   slave : the sink side of the same handshake
interface systolic_result_drain_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 2,
    parameter int unsigned CW = 2
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the ROWSxCOLS PE accumulators after a matrix
// product, streams them one word at a time over a valid/ready port, then pulses
// acc_clr toward the array.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse as the first skewed operand enters the array
//   c_flat      PE C outputs, PE(r,c) at [(r*COLS+c)*DW +: DW]
//   res         result stream (out_valid/out_ready/out_data/out_row/out_col/out_last)
//   acc_clr     one-cycle accumulator clear after the last word is accepted
//   busy        high whenever not idle
//   done        one-cycle pulse together with acc_clr
// Optional: define DRAIN_TRANSPOSE_EN for column-major stream order.
module systolic_result_drain #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned DW          = 16,
    parameter int unsigned WAIT_CYCLES = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ROWS*COLS*DW-1:0]   c_flat,
    systolic_result_drain_if.master   res,
    output logic                      acc_clr,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned NW = ROWS * COLS;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CAPTURE, S_STREAM, S_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q;
    logic [DW-1:0]   snap_q [NW];
    logic [RW-1:0]   row_q, row_nx;
    logic [CW-1:0]   col_q, col_nx;
    logic [DW-1:0]   data_q;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            acc_clr_q, acc_clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fire;
    logic            last_nx;

    function automatic logic [IW-1:0] flat_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(32'(r) * 32'(COLS) + 32'(c));
    endfunction

    assign fire = valid_q & res.out_ready;

    // Position of the word following (row_q, col_q) in stream order
    always_comb begin
        row_nx = row_q;
        col_nx = col_q;
`ifdef DRAIN_TRANSPOSE_EN
        if (row_q == RW'(ROWS - 1)) begin
            row_nx = '0;
            col_nx = col_q + CW'(1);
        end else begin
            row_nx = row_q + RW'(1);
        end
`else
        if (col_q == CW'(COLS - 1)) begin
            col_nx = '0;
            row_nx = row_q + RW'(1);
        end else begin
            col_nx = col_q + CW'(1);
        end
`endif
        last_nx = (row_nx == RW'(ROWS - 1)) && (col_nx == CW'(COLS - 1));
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            acc_clr_q <= acc_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_WAIT;
            S_WAIT:    if (cnt_q == '0) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_STREAM;
            S_STREAM:  if (fire && last_q) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of the registered control outputs
    always_comb begin
        valid_d   = 1'b0;
        last_d    = 1'b0;
        acc_clr_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_CAPTURE: begin
                valid_d = 1'b1;
                last_d  = (NW == 1);
            end
            S_STREAM: begin
                if (!fire) begin
                    valid_d = 1'b1;
                    last_d  = last_q;
                end else if (!last_q) begin
                    valid_d = 1'b1;
                    last_d  = last_nx;
                end else begin
                    acc_clr_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Wait counter, snapshot buffer and stream index/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            data_q <= '0;
            for (int i = 0; i < int'(NW); i++) snap_q[i] <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                cnt_q <= TW'(WAIT_CYCLES - 1);
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - TW'(1);
            end

            if (state_q == S_CAPTURE) begin
                for (int i = 0; i < int'(NW); i++) snap_q[i] <= c_flat[i*DW +: DW];
                row_q  <= '0;
                col_q  <= '0;
                data_q <= c_flat[DW-1:0];
            end else if (state_q == S_STREAM && fire) begin
                if (last_q) begin
                    row_q  <= '0;
                    col_q  <= '0;
                    data_q <= '0;
                end else begin
                    row_q  <= row_nx;
                    col_q  <= col_nx;
                    data_q <= snap_q[flat_idx(row_nx, col_nx)];
                end
            end
        end
    end

    assign res.out_valid = valid_q;
    assign res.out_last  = last_q;
    assign res.out_data  = data_q;
    assign res.out_row   = row_q;
    assign res.out_col   = col_q;
    assign acc_clr       = acc_clr_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: drain order, latency, backpressure,
// snapshot isolation, ignored start, and reset mid-stream.
`timescale 1ns/1ps
module tb_systolic_result_drain;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int WC   = 11;
    localparam int NW   = ROWS * COLS;

    typedef struct {
        logic        ready;
        logic        start;
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [NW*DW-1:0]     c_flat = '0;
    logic                 acc_clr, busy, done;
    int                   n_cmp = 0;
    int                   n_err = 0;
    vec_t                 vecs[$];

    systolic_result_drain_if #(.DW(DW), .RW(2), .CW(2)) out_if ();

    systolic_result_drain #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .WAIT_CYCLES(WC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .c_flat (c_flat),
        .res    (out_if),
        .acc_clr(acc_clr),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void pos(input int k, output int r, output int c);
`ifdef DRAIN_TRANSPOSE_EN
        r = k % ROWS;
        c = k / ROWS;
`else
        r = k / COLS;
        c = k % COLS;
`endif
    endfunction

    task automatic set_data(input int base);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                c_flat[(r*COLS+c)*DW +: DW] = 16'(base + r*256 + c);
    endtask

    // Expected stream: optional stall of stall_len cycles at word stall_k,
    // optional start pulse alongside word start_k.
    task automatic build(input int base, input int stall_k, input int stall_len, input int start_k);
        int r, c;
        vec_t v;
        vecs.delete();
        for (int k = 0; k < NW; k++) begin
            pos(k, r, c);
            v.data = 16'(base + r*256 + c);
            v.row  = 2'(r);
            v.col  = 2'(c);
            v.last = (k == NW - 1);
            v.start = 1'b0;
            v.ready = 1'b0;
            if (k == stall_k)
                for (int s = 0; s < stall_len; s++) vecs.push_back(v);
            v.ready = 1'b1;
            v.start = (k == start_k);
            vecs.push_back(v);
        end
    endtask

    // Called at a negedge; returns there with out_valid seen (or timed out).
    task automatic kick(input int base, input int ign_at);
        int lat;
        set_data(base);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!out_if.out_valid && lat < 40) begin
            if (lat == ign_at) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk("start_to_valid", 32'(lat), 32'(WC + 1));
    endtask

    task automatic apply(input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("valid[%0d]", i), 32'(out_if.out_valid), 32'd1);
            chk($sformatf("data[%0d]", i),  32'(out_if.out_data),  32'(vecs[i].data));
            chk($sformatf("row[%0d]", i),   32'(out_if.out_row),   32'(vecs[i].row));
            chk($sformatf("col[%0d]", i),   32'(out_if.out_col),   32'(vecs[i].col));
            chk($sformatf("last[%0d]", i),  32'(out_if.out_last),  32'(vecs[i].last));
            out_if.out_ready = vecs[i].ready;
            start = vecs[i].start;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        out_if.out_ready = 1'b0;
    endtask

    task automatic finish_check();
        int nv, nd, nb;
        chk("valid_after_last", 32'(out_if.out_valid), 32'd0);
        chk("acc_clr_pulse",    32'(acc_clr), 32'd1);
        chk("done_pulse",       32'(done),    32'd1);
        chk("busy_in_clear",    32'(busy),    32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("acc_clr_end", 32'(acc_clr), 32'd0);
        chk("done_end",    32'(done),    32'd0);
        chk("busy_end",    32'(busy),    32'd0);
        nv = 0; nd = 0; nb = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            nv += int'(out_if.out_valid);
            nd += int'(done);
            nb += int'(busy);
        end
        chk("quiet_valid", 32'(nv), 32'd0);
        chk("quiet_done",  32'(nd), 32'd0);
        chk("quiet_busy",  32'(nb), 32'd0);
    endtask

    initial begin
        int stall_k;
        out_if.out_ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",   32'(out_if.out_valid), 32'd0);
        chk("rst_last",    32'(out_if.out_last),  32'd0);
        chk("rst_data",    32'(out_if.out_data),  32'd0);
        chk("rst_row",     32'(out_if.out_row),   32'd0);
        chk("rst_col",     32'(out_if.out_col),   32'd0);
        chk("rst_acc_clr", 32'(acc_clr), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic drain
        build(0, -1, 0, -1);
        kick(0, -1);
        apply(vecs.size());
        finish_check();

        // Backpressure at word (1,2)
`ifdef DRAIN_TRANSPOSE_EN
        stall_k = 2*ROWS + 1;
`else
        stall_k = 1*COLS + 2;
`endif
        build(16'h1000, stall_k, 5, -1);
        kick(16'h1000, -1);
        apply(vecs.size());
        finish_check();

        // Snapshot isolation: overwrite c_flat right after capture
        build(16'h5000, -1, 0, -1);
        kick(16'h5000, -1);
        c_flat = '1;
        apply(vecs.size());
        finish_check();

        // Start ignored during WAIT and during STREAM
        build(16'h2000, -1, 0, 3);
        kick(16'h2000, 4);
        apply(vecs.size());
        finish_check();

        // Reset after 7 words
        build(0, -1, 0, -1);
        kick(0, -1);
        apply(7);
        out_if.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   32'(out_if.out_valid), 32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        chk("mid_rst_acc_clr", 32'(acc_clr), 32'd0);
        chk("mid_rst_data",    32'(out_if.out_data), 32'd0);
        out_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_rst_acc_clr", 32'(acc_clr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        build(16'h0300, -1, 0, -1);
        kick(16'h0300, -1);
        apply(vecs.size());
        finish_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
